// File: rtl/pid_mc_core.sv
// pid_mc_core: multi-channel, 4-stage pipelined fixed-point PID controller.
// Per-channel integral / previous-error state lives here; gains and limits are
// latched with each sample so changes only affect later samples.
// Optional feature macro: PID_ANTIWINDUP_EN (integral clamped to +/-INT_LIM).
module pid_mc_core #(
  parameter int VAL_LENGTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int CH_NUM     = 4,
  parameter int CH_W       = 2,
  parameter int INT_LIM    = 1 << 24
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_ch,
  input  logic signed [VAL_LENGTH-1:0] setpoint,
  input  logic signed [VAL_LENGTH-1:0] feedback,
  input  logic signed [VAL_LENGTH-1:0] kp,
  input  logic signed [VAL_LENGTH-1:0] ki,
  input  logic signed [VAL_LENGTH-1:0] kd,
  input  logic signed [VAL_LENGTH-1:0] uk_max,
  input  logic signed [VAL_LENGTH-1:0] uk_min,
  input  logic                         clr_valid,
  input  logic [CH_W-1:0]              clr_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_ch,
  output logic signed [VAL_LENGTH-1:0] uk,
  output logic                         sat_hi,
  output logic                         sat_lo
);
  localparam int VL = VAL_LENGTH;
  localparam int PW = 2 * VAL_LENGTH;
  localparam int SW = 2 * VAL_LENGTH + 2;
  localparam logic signed [VL-1:0] MAXV = {1'b0, {(VL-1){1'b1}}};
  localparam logic signed [VL-1:0] MINV = {1'b1, {(VL-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXS = SW'(MAXV);
  localparam logic signed [SW-1:0] MINS = SW'(MINV);
  localparam logic [CH_W:0]        CH_END = (CH_W+1)'(CH_NUM);

  // Clamp a one-bit-wider sum/difference back into VL bits instead of wrapping.
  function automatic logic signed [VL-1:0] f_sat(input logic signed [VL:0] x);
    if (x[VL] != x[VL-1]) f_sat = x[VL] ? MINV : MAXV;
    else                  f_sat = x[VL-1:0];
  endfunction

  // Handshake: a blocked output freezes the whole pipeline.
  logic       w_stall;
  logic [3:0] r_vld;
  assign w_stall   = r_vld[3] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_vld[3];

  // ---------------- S0: error and operand capture ----------------
  logic signed [VL-1:0] w_e;
  assign w_e = f_sat({setpoint[VL-1], setpoint} - {feedback[VL-1], feedback});

  logic signed [VL-1:0] r0_e, r0_kp, r0_ki, r0_kd, r0_umax, r0_umin;
  logic [CH_W-1:0]      r0_ch;

  // ---------------- S1: per-channel state read-modify-write ----------------
  logic signed [VL-1:0] r_int  [CH_NUM];
  logic signed [VL-1:0] r_prev [CH_NUM];
  logic                 w_ch_ok;
  logic signed [VL-1:0] w_i_old, w_p_old, w_i_sum, w_i_new, w_d;

  assign w_ch_ok = ({1'b0, r0_ch} < CH_END);
  assign w_i_old = w_ch_ok ? r_int[r0_ch]  : '0;
  assign w_p_old = w_ch_ok ? r_prev[r0_ch] : '0;
  assign w_i_sum = f_sat({w_i_old[VL-1], w_i_old} + {r0_e[VL-1], r0_e});
  assign w_d     = f_sat({r0_e[VL-1], r0_e} - {w_p_old[VL-1], w_p_old});

`ifdef PID_ANTIWINDUP_EN
  localparam logic signed [VL-1:0] LIM_P = VL'(INT_LIM);
  localparam logic signed [VL-1:0] LIM_N = VL'(-INT_LIM);
  assign w_i_new = (w_i_sum > LIM_P) ? LIM_P : (w_i_sum < LIM_N) ? LIM_N : w_i_sum;
`else
  logic w_unused_lim;
  assign w_unused_lim = ^INT_LIM;
  assign w_i_new      = w_i_sum;
`endif

  logic signed [VL-1:0] r1_e, r1_i, r1_d, r1_kp, r1_ki, r1_kd, r1_umax, r1_umin;
  logic [CH_W-1:0]      r1_ch;

  // ---------------- S2: products ----------------
  logic signed [PW-1:0] r2_pp, r2_pi, r2_pd;
  logic signed [VL-1:0] r2_umax, r2_umin;
  logic [CH_W-1:0]      r2_ch;

  // ---------------- S3: sum, rescale, saturate, clamp ----------------
  logic signed [SW-1:0] w_sum, w_sh;
  logic signed [VL-1:0] w_r;
  assign w_sum = SW'(r2_pp) + SW'(r2_pi) + SW'(r2_pd);
  assign w_sh  = w_sum >>> FRAC_BITS;
  assign w_r   = (w_sh > MAXS) ? MAXV : (w_sh < MINS) ? MINV : w_sh[VL-1:0];

  // Valid shift register: bit0=S0 ... bit3=output stage.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    r_vld <= '0;
    else if (!w_stall) r_vld <= {r_vld[2:0], in_valid};
  end

  // Channel state: clear beats the S1 write-back and ignores the stall.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_int[i]  <= '0;
        r_prev[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (clr_valid && clr_ch == CH_W'(i)) begin
          r_int[i]  <= '0;
          r_prev[i] <= '0;
        end else if (!w_stall && r_vld[0] && r0_ch == CH_W'(i)) begin
          r_int[i]  <= w_i_new;
          r_prev[i] <= r0_e;
        end
      end
    end
  end

  // Data pipeline S0..S2; every stage holds while stalled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r0_e <= '0; r0_kp <= '0; r0_ki <= '0; r0_kd <= '0;
      r0_umax <= '0; r0_umin <= '0; r0_ch <= '0;
      r1_e <= '0; r1_i <= '0; r1_d <= '0; r1_kp <= '0; r1_ki <= '0; r1_kd <= '0;
      r1_umax <= '0; r1_umin <= '0; r1_ch <= '0;
      r2_pp <= '0; r2_pi <= '0; r2_pd <= '0;
      r2_umax <= '0; r2_umin <= '0; r2_ch <= '0;
    end else if (!w_stall) begin
      if (in_valid) begin
        r0_e    <= w_e;
        r0_kp   <= kp;
        r0_ki   <= ki;
        r0_kd   <= kd;
        r0_umax <= uk_max;
        r0_umin <= uk_min;
        r0_ch   <= in_ch;
      end
      if (r_vld[0]) begin
        r1_e    <= r0_e;
        r1_i    <= w_ch_ok ? w_i_new : '0;
        r1_d    <= w_d;
        r1_kp   <= r0_kp;
        r1_ki   <= r0_ki;
        r1_kd   <= r0_kd;
        r1_umax <= r0_umax;
        r1_umin <= r0_umin;
        r1_ch   <= r0_ch;
      end
      if (r_vld[1]) begin
        r2_pp   <= PW'(r1_kp) * PW'(r1_e);
        r2_pi   <= PW'(r1_ki) * PW'(r1_i);
        r2_pd   <= PW'(r1_kd) * PW'(r1_d);
        r2_umax <= r1_umax;
        r2_umin <= r1_umin;
        r2_ch   <= r1_ch;
      end
    end
  end

  // Output stage: limit clamp with sat_hi priority; holds across stalls and bubbles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_ch <= '0;
      uk     <= '0;
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
    end else if (!w_stall && r_vld[2]) begin
      out_ch <= r2_ch;
      if (w_r > r2_umax) begin
        uk     <= r2_umax;
        sat_hi <= 1'b1;
        sat_lo <= 1'b0;
      end else if (w_r < r2_umin) begin
        uk     <= r2_umin;
        sat_hi <= 1'b0;
        sat_lo <= 1'b1;
      end else begin
        uk     <= w_r;
        sat_hi <= 1'b0;
        sat_lo <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pid_mc_core.sv
// Testbench for pid_mc_core: directed spec cases plus randomized traffic,
// checked against an in-order arithmetic reference model.
// Built with CH_NUM=3 so channel id 3 exercises the out-of-range path.
module tb_pid_mc_core;
  localparam int VL = 32, FB = 16, CHN = 3, CHW = 2;
`ifdef PID_ANTIWINDUP_EN
  localparam int ILIM = 25;
`else
  localparam int ILIM = 1 << 24;
`endif
  localparam longint MAX32 = 64'sh7fffffff;
  localparam longint MIN32 = -64'sh80000000;
  localparam logic signed [VL-1:0] ONE = 32'sh10000;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, clr_valid = 1'b0, out_valid, out_ready = 1'b1;
  logic sat_hi, sat_lo;
  logic [CHW-1:0] in_ch = '0, clr_ch = '0, out_ch;
  logic signed [VL-1:0] setpoint = '0, feedback = '0, kp = '0, ki = '0, kd = '0;
  logic signed [VL-1:0] uk_max = '0, uk_min = '0, uk;

  pid_mc_core #(.VAL_LENGTH(VL), .FRAC_BITS(FB), .CH_NUM(CHN), .CH_W(CHW), .INT_LIM(ILIM)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .setpoint(setpoint), .feedback(feedback), .kp(kp), .ki(ki), .kd(kd),
    .uk_max(uk_max), .uk_min(uk_min), .clr_valid(clr_valid), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .uk(uk),
    .sat_hi(sat_hi), .sat_lo(sat_lo));

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [CHW-1:0] ch; logic signed [VL-1:0] uk; logic hi; logic lo; } res_t;

  int checks = 0, errors = 0;
  res_t exp_q[$];
  logic signed [VL-1:0] got_uk[$];
  logic got_hi[$], got_lo[$];
  longint m_i[CHN], m_p[CHN];
  logic last_acc = 1'b0;
  bit was_stall = 1'b0;
  logic signed [VL-1:0] hold_uk;
  logic [CHW-1:0] hold_ch;
  logic hold_hi, hold_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat32(input longint x);
    return (x > MAX32) ? MAX32 : (x < MIN32) ? MIN32 : x;
  endfunction

  function automatic logic [63:0] g_uk(input int i);
    return (i < got_uk.size()) ? 64'(got_uk[i]) : 'x;
  endfunction
  function automatic logic [63:0] g_hi(input int i);
    return (i < got_hi.size()) ? 64'(got_hi[i]) : 'x;
  endfunction
  function automatic logic [63:0] g_lo(input int i);
    return (i < got_lo.size()) ? 64'(got_lo[i]) : 'x;
  endfunction

  // Reference: PID law on plain integers, state updated in acceptance order.
  task automatic model_accept(input int ch, input logic signed [VL-1:0] sp, fb, kpv, kiv, kdv,
                              umx, umn);
    longint e, iu, d, r;
    logic signed [127:0] s;
    res_t x;
    e = sat32(longint'(sp) - longint'(fb));
    if (ch < CHN) begin
      iu = sat32(m_i[ch] + e);
`ifdef PID_ANTIWINDUP_EN
      if (iu > ILIM) iu = ILIM;
      else if (iu < -ILIM) iu = -ILIM;
`endif
      d = sat32(e - m_p[ch]);
      m_i[ch] = iu;
      m_p[ch] = e;
    end else begin
      iu = 0;
      d  = e;
    end
    s = 128'(kpv) * 128'(e) + 128'(kiv) * 128'(iu) + 128'(kdv) * 128'(d);
    s = s >>> FB;
    r = (s > 128'(MAX32)) ? MAX32 : (s < 128'(MIN32)) ? MIN32 : longint'(s);
    x.ch = CHW'(ch);
    x.hi = 1'b0;
    x.lo = 1'b0;
    if (r > longint'(umx)) begin x.uk = umx; x.hi = 1'b1; end
    else if (r < longint'(umn)) begin x.uk = umn; x.lo = 1'b1; end
    else x.uk = 32'(r);
    exp_q.push_back(x);
  endtask

  // One clock: inputs already driven at the negedge; checks at negedge+1.
  task automatic step();
    logic acc, ret, stl;
    res_t ex;
    #1;
    acc = in_valid && in_ready;
    ret = out_valid && out_ready;
    stl = out_valid && !out_ready;
    chk("in_ready", in_ready, !stl);
    if (was_stall) begin
      chk("stall_uk", uk, hold_uk);
      chk("stall_ch", out_ch, hold_ch);
      chk("stall_hi", sat_hi, hold_hi);
      chk("stall_lo", sat_lo, hold_lo);
    end
    if (ret) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        ex = exp_q.pop_front();
        chk("out_ch", out_ch, ex.ch);
        chk("uk", uk, ex.uk);
        chk("sat_hi", sat_hi, ex.hi);
        chk("sat_lo", sat_lo, ex.lo);
        got_uk.push_back(uk);
        got_hi.push_back(sat_hi);
        got_lo.push_back(sat_lo);
      end
    end
    was_stall = stl;
    hold_uk = uk; hold_ch = out_ch; hold_hi = sat_hi; hold_lo = sat_lo;
    @(posedge sys_clk);
    if (clr_valid && clr_ch < CHN) begin
      m_i[clr_ch] = 0;
      m_p[clr_ch] = 0;
    end
    if (acc) model_accept(int'(in_ch), setpoint, feedback, kp, ki, kd, uk_max, uk_min);
    last_acc = acc;
    @(negedge sys_clk);
  endtask

  task automatic send(input int ch, input logic signed [VL-1:0] sp, input logic signed [VL-1:0] fb);
    in_valid = 1'b1;
    in_ch = CHW'(ch);
    setpoint = sp;
    feedback = fb;
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_acc) break;
    end
    chk("accept", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic clear(input int ch);
    clr_valid = 1'b1;
    clr_ch = CHW'(ch);
    step();
    clr_valid = 1'b0;
  endtask

  task automatic clr_got();
    got_uk.delete(); got_hi.delete(); got_lo.delete();
  endtask

  function automatic logic signed [VL-1:0] rnd_val();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  function automatic logic signed [VL-1:0] rnd_gain();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return int'($urandom_range(0, 32'h40000)) - 32'sh20000;
  endfunction

  initial begin
    for (int i = 0; i < CHN; i++) begin m_i[i] = 0; m_p[i] = 0; end
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_uk", uk, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_sat_hi", sat_hi, 1'b0);
    chk("rst_sat_lo", sat_lo, 1'b0);
    sys_rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1'b1);
    @(negedge sys_clk);
    uk_max = 1000; uk_min = -1000;

    // P only, with latency
    kp = ONE; ki = 0; kd = 0;
    clr_got();
    send(0, 100, 40);
    step(); step();
    chk("lat_e2", out_valid, 1'b0);
    step();
    chk("lat_e3", out_valid, 1'b1);
    drain();
    chk("p_only", g_uk(0), 60);

    // I only, interleaved channels, then clear
    clear(1); clear(2);
    kp = 0; ki = ONE; kd = 0;
    clr_got();
    send(1, 10, 0); send(2, 0, 7); send(1, 10, 0); send(2, 0, 7); send(1, 10, 0);
    drain();
    chk("i_c1_0", g_uk(0), 10);  chk("i_c2_0", g_uk(1), -7);
    chk("i_c1_1", g_uk(2), 20);  chk("i_c2_1", g_uk(3), -14);
    chk("i_c1_2", g_uk(4), 30);
    clear(1);
    clr_got();
    send(1, 10, 0);
    drain();
    chk("i_after_clr", g_uk(0), 10);

    // D only, then fractional P with floor rounding
    clear(0);
    kp = 0; ki = 0; kd = ONE;
    clr_got();
    send(0, 5, 0); send(0, 8, 0);
    drain();
    chk("d_0", g_uk(0), 5);
    chk("d_1", g_uk(1), 3);
    kp = 32'sh8000; kd = 0;
    clr_got();
    send(0, 3, 0); send(0, -3, 0);
    drain();
    chk("half_pos", g_uk(0), 1);
    chk("half_neg", g_uk(1), -2);

    // Output clamp
    kp = ONE; ki = 0; kd = 0; uk_max = 50;
    clr_got();
    send(0, 100, 0);
    uk_min = -50;
    send(0, -100, 0);
    drain();
    chk("clamp_hi", g_uk(0), 50);  chk("clamp_hi_f", g_hi(0), 1);
    chk("clamp_lo", g_uk(1), -50); chk("clamp_lo_f", g_lo(1), 1);
    uk_max = 1000; uk_min = -1000;

    // Stall: output held, input refused
    clr_got();
    send(0, 30, 0); send(0, 40, 0);
    for (int k = 0; k < 10 && !out_valid; k++) step();
    chk("stall_head", out_valid, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 0; setpoint = 77; feedback = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_noacc", last_acc, 1'b0);
    end
    in_valid = 1'b0;
    drain();
    chk("stall_r0", g_uk(0), 30);
    chk("stall_r1", g_uk(1), 40);

    // Out-of-range channel: I=0, D=e, state untouched
    kp = ONE; ki = ONE; kd = ONE;
    clr_got();
    send(3, 7, 0); send(3, 7, 0);
    drain();
    chk("badch_0", g_uk(0), 14);
    chk("badch_1", g_uk(1), 14);

    // Clear on the same edge as the S1 write-back of that channel
    clear(1);
    kp = 0; ki = ONE; kd = 0;
    clr_got();
    send(1, 10, 0);
    clr_valid = 1'b1; clr_ch = 1;
    step();
    clr_valid = 1'b0;
    send(1, 10, 0);
    drain();
    chk("clrwin_0", g_uk(0), 10);
    chk("clrwin_1", g_uk(1), 10);

    // Inverted limits: uk_max wins when r exceeds it
    kp = ONE; ki = 0; kd = 0; uk_max = -10; uk_min = 10;
    clr_got();
    send(0, 0, 0); send(0, -20, 0);
    drain();
    chk("inv_0", g_uk(0), -10); chk("inv_0_hi", g_hi(0), 1);
    chk("inv_1", g_uk(1), 10);  chk("inv_1_lo", g_lo(1), 1);

    // Range extremes: error saturation and wide-sum saturation
    uk_max = 32'sh7fffffff; uk_min = 32'sh80000000;
    clear(0);
    clr_got();
    send(0, 32'sh7fffffff, 32'sh80000000);
    send(0, 32'sh80000000, 32'sh7fffffff);
    clear(2);
    kp = 32'sh7fffffff; ki = 32'sh7fffffff; kd = 32'sh7fffffff;
    send(2, 32'sh7fffffff, 32'sh80000000);
    drain();
    chk("esat_hi", g_uk(0), 32'sh7fffffff);
    chk("esat_lo", g_uk(1), 32'sh80000000);
    chk("wide_sat", g_uk(2), 32'sh7fffffff);

    // Integral growth (clamped by INT_LIM when anti-windup is built in)
    uk_max = 1000; uk_min = -1000;
    kp = 0; ki = ONE; kd = 0;
    clear(2);
    clr_got();
    for (int k = 0; k < 4; k++) send(2, 10, 0);
    drain();
    chk("int_0", g_uk(0), 10);
    chk("int_1", g_uk(1), 20);
`ifdef PID_ANTIWINDUP_EN
    chk("int_2", g_uk(2), 25);
    chk("int_3", g_uk(3), 25);
`else
    chk("int_2", g_uk(2), 30);
    chk("int_3", g_uk(3), 40);
`endif

    // Randomized traffic with stalls, clears and gain/limit changes
    for (int c = 0; c < 2000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_ch = CHW'($urandom_range(0, 3));
      setpoint = rnd_val();
      feedback = rnd_val();
      if ($urandom_range(0, 15) == 0) begin
        kp = rnd_gain(); ki = rnd_gain(); kd = rnd_gain();
      end
      if ($urandom_range(0, 31) == 0) begin
        uk_max = int'($urandom_range(0, 3000));
        uk_min = -int'($urandom_range(0, 3000));
        if ($urandom_range(0, 7) == 0) begin uk_max = -uk_max; uk_min = -uk_min; end
        if ($urandom_range(0, 7) == 0) begin uk_max = 32'sh7fffffff; uk_min = 32'sh80000000; end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_valid = ($urandom_range(0, 19) == 0) && !(out_valid && !out_ready);
      clr_ch = CHW'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0; clr_valid = 1'b0;
    drain();

    // Reset with samples in flight: nothing emerges, state zeroed
    kp = ONE; ki = ONE; kd = 0; uk_max = 1000; uk_min = -1000;
    send(1, 5, 0); send(2, 6, 0);
    sys_rst_n = 1'b0;
    #1 chk("mid_rst_valid", out_valid, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < CHN; i++) begin m_i[i] = 0; m_p[i] = 0; end
    was_stall = 1'b0;
    for (int k = 0; k < 6; k++) step();
    kp = 0;
    clr_got();
    send(1, 10, 0);
    drain();
    chk("post_rst", g_uk(0), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
